// File: rtl/qspi_target_if.sv
// Quad-SPI pin bundle between an initiator (master) and the target (slave).
//
// Handshake: there is no valid/ready pair on this link. A transfer is framed
// by cs_n: while cs_n is low every rising clk edge moves exactly one nibble
// (io_in from initiator, io_out from target when io_oe=4'hF); cs_n high at a
// rising edge ends or aborts the transfer at that same edge.
interface qspi_target_if;
    logic       cs_n;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;

    modport master (
        output cs_n,
        output io_in,
        input  io_out,
        input  io_oe
    );

    modport slave (
        input  cs_n,
        input  io_in,
        output io_out,
        output io_oe
    );
endinterface

// File: rtl/qspi_target.sv
// Quad-SPI memory responder: decodes a two-nibble opcode and a 24-bit
// address, then streams read data out of (or commits write data into) a
// small byte array. The SPI clock is the system clock.
module qspi_target #(
    parameter int         DEPTH     = 256,
    parameter int         DUMMY     = 4,
    parameter logic [7:0] READ_CMD  = 8'hEB,
    parameter logic [7:0] WRITE_CMD = 8'h38
) (
    input  logic          clk,
    input  logic          reset,
    qspi_target_if.slave  bus,
    output logic          busy,
    output logic          cmd_err,
    output logic [2:0]    state_dbg
);

    localparam int AW = $clog2(DEPTH);
    // Counter must reach 5 for the address phase and DUMMY-1 for dummies.
    localparam int CW = ($clog2(DUMMY) > 3) ? $clog2(DUMMY) : 3;
    localparam logic [CW-1:0] ADDR_LAST  = CW'(5);
    localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      cmd_hi_q, cmd_hi_d;
    logic            rd_op_q, rd_op_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            half_q, half_d;
    logic [3:0]      wr_hi_q, wr_hi_d;
    logic [3:0]      io_out_q, io_out_d;
    logic [3:0]      io_oe_q, io_oe_d;
    logic            cmd_err_q, cmd_err_d;

    logic            mem_we;
    logic [7:0]      mem_wdata;
    logic [7:0]      rd_byte;
    logic [7:0]      opcode;

    // Backing store; deliberately not reset so contents survive a reset.
    logic [7:0] mem [DEPTH];

    assign rd_byte = mem[ptr_q];
    assign opcode  = {cmd_hi_q, bus.io_in};

    // Next-state and datapath decode; cs_n high overrides every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_hi_d  = cmd_hi_q;
        rd_op_d   = rd_op_q;
        ptr_d     = ptr_q;
        half_d    = half_q;
        wr_hi_d   = wr_hi_q;
        io_out_d  = 4'h0;
        io_oe_d   = 4'h0;
        cmd_err_d = cmd_err_q;
        mem_we    = 1'b0;
        mem_wdata = {wr_hi_q, bus.io_in};

        if (bus.cs_n) begin
            // Abort or idle: drop any partial byte and phase progress.
            state_d = S_IDLE;
            cnt_d   = '0;
            half_d  = 1'b0;
            ptr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_hi_d = bus.io_in;
                    state_d  = S_CMD;
                end
                S_CMD: begin
                    cnt_d = '0;
                    if (opcode == READ_CMD) begin
                        rd_op_d = 1'b1;
                        state_d = S_ADDR;
                    end else if (opcode == WRITE_CMD) begin
                        rd_op_d = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = S_IGNORE;
                    end
                end
                S_ADDR: begin
                    // Only the low AW address bits survive the shift.
                    ptr_d = AW'({ptr_q, bus.io_in});
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d  = '0;
                        half_d = 1'b0;
                        if (!rd_op_q)        state_d = S_WDATA;
                        else if (DUMMY == 0) state_d = S_RDATA;
                        else                 state_d = S_DUMMY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DUMMY: begin
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RDATA: begin
                    io_oe_d  = 4'hF;
                    io_out_d = half_q ? rd_byte[3:0] : rd_byte[7:4];
                    half_d   = ~half_q;
                    if (half_q) ptr_d = ptr_q + AW'(1);
                end
                S_WDATA: begin
                    if (!half_q) begin
                        wr_hi_d = bus.io_in;
                        half_d  = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        half_d = 1'b0;
                        ptr_d  = ptr_q + AW'(1);
                    end
                end
                S_IGNORE: begin
                    state_d = S_IGNORE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_hi_q  <= 4'h0;
            rd_op_q   <= 1'b0;
            ptr_q     <= '0;
            half_q    <= 1'b0;
            wr_hi_q   <= 4'h0;
            io_out_q  <= 4'h0;
            io_oe_q   <= 4'h0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_hi_q  <= cmd_hi_d;
            rd_op_q   <= rd_op_d;
            ptr_q     <= ptr_d;
            half_q    <= half_d;
            wr_hi_q   <= wr_hi_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Byte commit on the edge that captures the low nibble.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q] <= mem_wdata;
    end

    assign bus.io_out = io_out_q;
    assign bus.io_oe  = io_oe_q;
    assign busy       = (state_q != S_IDLE);
    assign cmd_err    = cmd_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_qspi_target.sv
// Self-checking bench for qspi_target: directed cases from the datasheet
// examples plus randomized read/write/bad-opcode transactions checked
// against a transaction-level byte-array model.
module tb_qspi_target;

    localparam int DEPTH = 256;
    localparam int DUMMY = 4;
    localparam logic [7:0] RD_OP = 8'hEB;
    localparam logic [7:0] WR_OP = 8'h38;

    logic       clk;
    logic       reset;
    logic       busy;
    logic       cmd_err;
    logic [2:0] state_dbg;

    qspi_target_if bus ();

    qspi_target #(
        .DEPTH(DEPTH), .DUMMY(DUMMY), .READ_CMD(RD_OP), .WRITE_CMD(WR_OP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .busy(busy), .cmd_err(cmd_err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic        err_exp = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  wr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One SPI cycle: drive on negedge, let the posedge happen, settle 1ns.
    task automatic tick(input logic cs, input logic [3:0] nib);
        @(negedge clk);
        bus.cs_n  = cs;
        bus.io_in = nib;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        tick(1'b0, op[7:4]);
        check("busy_cmd", 32'(busy), 32'd1);
        tick(1'b0, op[3:0]);
        check("oe_cmd", 32'(bus.io_oe), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, addr[23-4*i -: 4]);
            check("oe_addr", 32'(bus.io_oe), 32'h0);
        end
    endtask

    task automatic end_txn();
        tick(1'b1, 4'($urandom));
        check("busy_end", 32'(busy), 32'd0);
        check("oe_end", 32'(bus.io_oe), 32'h0);
        check("cmd_err", 32'(cmd_err), 32'(err_exp));
    endtask

    // Write the nibbles queued in wr_q; only whole bytes reach memory.
    task automatic do_write(input logic [23:0] addr);
        int n;
        n = wr_q.size();
        send_hdr(WR_OP, addr);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, wr_q[i]);
            check("oe_wdata", 32'(bus.io_oe), 32'h0);
        end
        end_txn();
        for (int j = 0; j + 1 < n; j += 2)
            ref_mem[(int'(addr) + j / 2) % DEPTH] = {wr_q[j], wr_q[j+1]};
        wr_q.delete();
    endtask

    task automatic push_expected(input logic [23:0] addr, input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = ref_mem[(int'(addr) + k / 2) % DEPTH];
            exp_q.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
        end
    endtask

    task automatic do_read(input logic [23:0] addr, input int n);
        push_expected(addr, n);
        send_hdr(RD_OP, addr);
        for (int d = 0; d < DUMMY; d++) begin
            tick(1'b0, 4'($urandom));
            check("oe_dummy", 32'(bus.io_oe), 32'h0);
        end
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 4'($urandom));
            check("oe_rdata", 32'(bus.io_oe), 32'hF);
            check("rdata", 32'(bus.io_out), 32'(exp_q.pop_front()));
        end
        end_txn();
    endtask

    task automatic do_bad(input logic [7:0] op, input int extra);
        tick(1'b0, op[7:4]);
        tick(1'b0, op[3:0]);
        err_exp = 1'b1;
        check("cmd_err_set", 32'(cmd_err), 32'd1);
        for (int i = 0; i < extra; i++) begin
            tick(1'b0, 4'($urandom));
            check("oe_ignore", 32'(bus.io_oe), 32'h0);
            check("busy_ignore", 32'(busy), 32'd1);
        end
        end_txn();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [23:0] a;
        logic [7:0]  op;
        int          n;
        int          kind;

        bus.cs_n  = 1'b1;
        bus.io_in = 4'h0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'(bus.io_oe), 32'h0);
        check("rst_out", 32'(bus.io_out), 32'h0);
        check("rst_err", 32'(cmd_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill the whole array so the model starts from known contents.
        for (int i = 0; i < 2 * DEPTH; i++) wr_q.push_back(4'($urandom));
        do_write(24'h0);

        // Datasheet write / read at 0x10.
        wr_q = '{4'hA, 4'h5, 4'h3, 4'hC};
        do_write(24'h000010);
        check("mem10", 32'(ref_mem[8'h10]), 32'hA5);
        do_read(24'h000010, 4);

        // Wrap at the top of the array, write and read.
        wr_q = '{4'h1, 4'h1, 4'h2, 4'h2};
        do_write(24'(DEPTH - 1));
        do_read(24'(DEPTH - 1), 4);

        // Abort after a byte and a half: 0x20 written, 0x21 untouched.
        wr_q = '{4'h7, 4'hE, 4'h9};
        do_write(24'h000020);
        do_read(24'h000020, 4);

        // Abort inside the address phase: nothing executes.
        tick(1'b0, WR_OP[7:4]);
        tick(1'b0, WR_OP[3:0]);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'h0);
        end_txn();
        do_read(24'h000000, 6);

        // Bad opcode: sticky error, ignored payload, later read still works.
        do_bad(8'h55, 10);
        do_read(24'h000010, 4);

        // Randomized transactions; upper address bits are random too.
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            a    = 24'($urandom);
            if (kind == 0) begin
                op = 8'($urandom);
                if (op == RD_OP || op == WR_OP) op = 8'h00;
                do_bad(op, $urandom_range(0, 6));
            end else if (kind < 5) begin
                n = $urandom_range(1, 12);
                for (int i = 0; i < n; i++) wr_q.push_back(4'($urandom));
                do_write(a);
            end else begin
                do_read(a, $urandom_range(1, 24));
            end
        end

        // Reset while streaming read data.
        a = 24'h0000F0;
        push_expected(a, 3);
        send_hdr(RD_OP, a);
        for (int d = 0; d < DUMMY; d++) tick(1'b0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 4'h0);
            check("pre_rst_rdata", 32'(bus.io_out), 32'(exp_q.pop_front()));
        end
        reset = 1'b0;
        #1;
        err_exp = 1'b0;
        check("rst_mid_oe", 32'(bus.io_oe), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_err", 32'(cmd_err), 32'd0);
        bus.cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        do_read(a, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Cycle budget so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
